decoder_scan_sequencer: RTL
===========================

// Module: decoder_scan_sequencer
// PURPOSE
//  Upstream driver for the 5-to-32 decoder: produces its select index and enable.
//  - Steps the index from first_idx to last_idx, modulo 2**SEL_W.
//  - Holds each index for dwell+1 cycles, then pulses done.
//  - Used to sweep decoder outputs for scanning, strobing and self-test.
// PARAMETERS
//  SEL_W    5  width of select index; decoder has 2**SEL_W outputs
//  DWELL_W  8  width of dwell count; each index held dwell+1 cycles
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        begin a scan; sampled only in IDLE
//  abort      in   1        terminate scan; no done pulse
//  first_idx  in   SEL_W    first index; latched on accepted start
//  last_idx   in   SEL_W    last index; latched on accepted start
//  dwell      in   DWELL_W  hold count per index; latched on accepted start
//  loop       in   1        continuous mode request (only with SCAN_LOOP_EN)
//  sel        out  SEL_W    to decoder in[]; registered
//  sel_en     out  1        to decoder en; registered
//  busy       out  1        high while in SCAN
//  done       out  1        one-cycle pulse at normal scan completion
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=IDLE; sel=0, sel_en=0, busy=0, done=0.
//  - FSM states: IDLE, SCAN.
//  - IDLE -> SCAN when start=1 and abort=0 at edge T. At edge T+1:
//      sel=first_idx, sel_en=1, busy=1, dwell counter loaded with dwell.
//  - In SCAN, when the counter reaches 0:
//      - sel != last: sel <= sel+1 (wraps 2**SEL_W-1 -> 0); counter reloads.
//      - sel == last: -> IDLE; sel_en=0, busy=0, done=1 for exactly one cycle.
//  - Scan length:
//      - N = ((last-first) mod 2**SEL_W)+1 indices.
//      - sel_en is high for N*(dwell+1) consecutive cycles.
//  - Boundaries:
//      - first==last gives a single index.
//      - first>last wraps through 0; e.g. 30,31,0,1.
//      - first=0, last=31 covers all 32 indices.
//      - dwell=0 advances every cycle.
//  - sel holds its last value in IDLE. Decoder outputs are gated by sel_en=0.
//  - abort=1 in SCAN: next edge -> IDLE, sel_en=0, busy=0, done stays 0.
//    Abort on the final dwell cycle also suppresses done.
//  - start while busy: ignored. Latched parameters do not change mid-scan.
//  - start and abort in the same IDLE cycle: abort wins; state stays IDLE.
//  - rst_n low mid-scan: outputs go to reset values immediately (asynchronous).
// CONFIGURATION
//  Macro SCAN_LOOP_EN:
//  - Defined:
//      - loop port exists and is sampled live at the last index's final dwell cycle.
//      - loop=1: sel <= first_idx (latched) with no gap cycle; sel_en stays 1;
//        no done pulse.
//      - loop=0: normal completion with done.
//      - abort is the only other way out.
//  - Undefined: loop port absent; single pass only.
// STRUCTURE
//  Package decoder_scan_pkg:
//  - SEL_W/DWELL_W defaults.
//  - State encodings ST_IDLE=1'b0, ST_SCAN=1'b1.
//  - Index-increment-with-wrap function.
//  Sub-module scan_dwell_counter:
//  - Loadable DWELL_W down-counter; ports load, load_val, en, zero.
//  - Instantiated once.
//  Top level holds the FSM, latched range registers and output registers.
// TESTING
//  - Reset: rst_n=0 -> sel=0, sel_en=0, busy=0, done=0; start ignored while rst_n=0.
//  - first=0, last=4, dwell=0, start:
//      sel 0..4 on 5 consecutive cycles, sel_en=1;
//      done=1 on the 6th cycle with sel_en=0, busy=0.
//  - first=30, last=1, dwell=2:
//      sel 30,31,0,1, each held 3 cycles (12 cycles sel_en=1);
//      then done pulse.
//  - first=last=7, dwell=3:
//      sel=7 for 4 cycles, then done.
//      Second start pulsed while busy: no effect.
//  - first=0, last=31, dwell=5, abort at cycle 20 of scan:
//      next cycle sel_en=0, busy=0, done never asserts.
//      Also: start+abort in same IDLE cycle -> busy stays 0.
//  - SCAN_LOOP_EN, first=2, last=3, dwell=0, loop=1:
//      sel 2,3,2,3 continuous, no done.
//      Drop loop before the 2nd pass -> done after that pass's sel=3.

Source files
------------

// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer: default widths,
// FSM state encodings and the wrapping index-increment helper.
// Optional feature macro used elsewhere in this slice: SCAN_LOOP_EN.
package decoder_scan_pkg;

    localparam int SEL_W_DEF   = 5;
    localparam int DWELL_W_DEF = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // Next index modulo 2**w; callers truncate the result to their width.
    function automatic logic [31:0] idx_next(input logic [31:0] idx, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (idx + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan requester (master) and the
// decoder scan sequencer (slave). The loop request exists only when
// SCAN_LOOP_EN is defined.
interface decoder_scan_sequencer_if #(
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
);
    logic               start;
    logic               abort;
    logic [SEL_W-1:0]   first_idx;
    logic [SEL_W-1:0]   last_idx;
    logic [DWELL_W-1:0] dwell;
`ifdef SCAN_LOOP_EN
    logic               loop;
`endif
    logic [SEL_W-1:0]   sel;
    logic               sel_en;
    logic               busy;
    logic               done;

`ifdef SCAN_LOOP_EN
    modport master (output start, abort, first_idx, last_idx, dwell, loop,
                    input  sel, sel_en, busy, done);
    modport slave  (input  start, abort, first_idx, last_idx, dwell, loop,
                    output sel, sel_en, busy, done);
`else
    modport master (output start, abort, first_idx, last_idx, dwell,
                    input  sel, sel_en, busy, done);
    modport slave  (input  start, abort, first_idx, last_idx, dwell,
                    output sel, sel_en, busy, done);
`endif
endinterface

// File: rtl/decoder_scan_sequencer_dwell_counter.sv
// Loadable down-counter that times how long each index is held.
// zero flags the final dwell cycle of the current index.
module scan_dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);
    logic [DWELL_W-1:0] cnt_d, cnt_q;

    // Load has priority; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/decoder_scan_sequencer.sv
// Decoder scan sequencer: sweeps sel from first_idx to last_idx (mod
// 2**SEL_W), holding each index dwell+1 cycles, then pulses done.
// Define SCAN_LOOP_EN to allow continuous rescans while loop is held.
module decoder_scan_sequencer
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    decoder_scan_sequencer_if.slave bus
);
    logic [0:0]         state_d, state_q;
    logic [SEL_W-1:0]   sel_d, sel_q;
    logic               sel_en_d, sel_en_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic [SEL_W-1:0]   first_d, first_q;
    logic [SEL_W-1:0]   last_d, last_q;
    logic [DWELL_W-1:0] dwell_d, dwell_q;

    logic               cnt_load;
    logic [DWELL_W-1:0] cnt_load_val;
    logic               cnt_en;
    logic               cnt_zero;
    logic               rescan;

    scan_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Continuous-mode request, sampled live at the last index's final cycle.
`ifdef SCAN_LOOP_EN
    assign rescan = bus.loop;
`else
    assign rescan = 1'b0;
`endif

    // Scan FSM: start/abort handling, index stepping and completion.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_en_d     = sel_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        first_d      = first_q;
        last_d       = last_q;
        dwell_d      = dwell_q;
        cnt_load     = 1'b0;
        cnt_load_val = dwell_q;
        cnt_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort wins over a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d      = ST_SCAN;
                    sel_d        = bus.first_idx;
                    sel_en_d     = 1'b1;
                    busy_d       = 1'b1;
                    first_d      = bus.first_idx;
                    last_d       = bus.last_idx;
                    dwell_d      = bus.dwell;
                    cnt_load     = 1'b1;
                    cnt_load_val = bus.dwell;
                end
            end
            default: begin
                if (bus.abort) begin
                    state_d  = ST_IDLE;
                    sel_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end else if (sel_q != last_q) begin
                    sel_d    = SEL_W'(idx_next(32'(sel_q), SEL_W));
                    cnt_load = 1'b1;
                end else if (rescan) begin
                    // restart at the latched first index with no gap cycle
                    sel_d    = first_q;
                    cnt_load = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    sel_en_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
        endcase
    end

    // Control and output registers; sel holds its value across IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Scan range and dwell captured on an accepted start.
    always_ff @(posedge clk) begin
        first_q <= first_d;
        last_q  <= last_d;
        dwell_q <= dwell_d;
    end

    assign bus.sel    = sel_q;
    assign bus.sel_en = sel_en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
